afe_inj_pulser: RTL and testbench

//  Programmable injection-pulse generator; drives the AFE CPLD INJ_IN input directly.
//  - INJ high opens the TOT window. INJ low clears the TOT counter and HIT.
//  - Produces a burst of NUM_PULSES pulses: configurable start delay, high width and period.
//  - Replaces manual/external injection so threshold and TOT scans run unattended.

---
 rtl/afe_inj_pulser_pkg.sv | 14 +
 rtl/afe_phase_counter.sv | 30 +++
 rtl/afe_inj_pulser.sv | 165 ++++++++++++++++
 tb/tb_afe_inj_pulser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_inj_pulser_pkg.sv
// Shared definitions for the AFE injection pulser: FSM state encoding and default widths.
package afe_inj_pulser_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_NUM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/afe_phase_counter.sv
// Loadable down-counter timing the DLY/HIGH/LOW phases; o_tc flags the last cycle of a phase.
module afe_phase_counter
  import afe_inj_pulser_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Load phase length minus one on a state change, otherwise count down to zero and hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/afe_inj_pulser.sv
// Programmable injection-pulse burst generator driving the AFE CPLD INJ_IN input.
module afe_inj_pulser
  import afe_inj_pulser_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] DELAY,
  input  logic [CNT_W-1:0] WIDTH,
  input  logic [CNT_W-1:0] PERIOD,
  input  logic [NUM_W-1:0] NUM_PULSES,
  output logic             INJ_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [NUM_W-1:0] PULSE_CNT
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_pulse_cnt;
  logic [NUM_W-1:0] w_cnt_base;
  logic             r_inj;
  logic             r_busy;
  logic             r_done;
  logic             w_done_next;
  logic             w_start_ok;
  logic             w_tc;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_delay_sel;
  logic [CNT_W-1:0] w_width_sel;
  logic [CNT_W-1:0] w_period_sel;
  logic [CNT_W-1:0] w_high_len;
  logic [CNT_W-1:0] w_high_m1;
  logic [CNT_W-1:0] w_low_m1;
  logic [CNT_W-1:0] w_dly_m1;

  assign w_start_ok = (r_state == ST_IDLE) && START && !ABORT;

  // While idle the phase lengths come straight from the inputs being latched this edge.
  assign w_delay_sel  = (r_state == ST_IDLE) ? DELAY  : r_delay;
  assign w_width_sel  = (r_state == ST_IDLE) ? WIDTH  : r_width;
  assign w_period_sel = (r_state == ST_IDLE) ? PERIOD : r_period;

  // high_len = max(WIDTH,1); low_len = max(PERIOD-high_len,1), compared before subtracting.
  assign w_high_len = (w_width_sel == '0) ? CNT_W'(1) : w_width_sel;
  assign w_high_m1  = w_high_len - CNT_W'(1);
  assign w_low_m1   = (w_period_sel > w_high_len) ? (w_period_sel - w_high_len - CNT_W'(1)) : '0;
  assign w_dly_m1   = (w_delay_sel == '0) ? '0 : (w_delay_sel - CNT_W'(1));

  // Next-state and done-strobe decode; ABORT takes priority in every active state.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_state_next = (DELAY != '0) ? ST_DLY : ST_HIGH;
      end
      ST_DLY: begin
        if (ABORT)     w_state_next = ST_IDLE;
        else if (w_tc) w_state_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (ABORT)     w_state_next = ST_IDLE;
        else if (w_tc) w_state_next = ST_LOW;
      end
      ST_LOW: begin
        if (ABORT) begin
          w_state_next = ST_IDLE;
        end else if (w_tc) begin
          if ((r_num == '0) || (r_pulse_cnt < r_num)) begin
            w_state_next = ST_HIGH;
          end else begin
            w_state_next = ST_IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Phase counter reload value follows the state being entered.
  always_comb begin
    w_load_val = '0;
    case (w_state_next)
      ST_DLY:  w_load_val = w_dly_m1;
      ST_HIGH: w_load_val = w_high_m1;
      ST_LOW:  w_load_val = w_low_m1;
      default: w_load_val = '0;
    endcase
  end

  assign w_load = (w_state_next != r_state);

  afe_phase_counter #(.CNT_W(CNT_W)) u_phase (
    .i_clk      (CLK),
    .i_rst_b    (RST_B),
    .i_load     (w_load),
    .i_en       (r_state != ST_IDLE),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_B) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Burst settings are captured only when a START is accepted.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_delay  <= '0;
      r_width  <= '0;
      r_period <= '0;
      r_num    <= '0;
    end else if (w_start_ok) begin
      r_delay  <= DELAY;
      r_width  <= WIDTH;
      r_period <= PERIOD;
      r_num    <= NUM_PULSES;
    end
  end

  assign w_cnt_base = w_start_ok ? '0 : r_pulse_cnt;

  // Count each entry into HIGH, saturating at all-ones; accepted START clears first.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_pulse_cnt <= '0;
    end else if ((w_state_next == ST_HIGH) && (r_state != ST_HIGH)) begin
      r_pulse_cnt <= (w_cnt_base == '1) ? w_cnt_base : (w_cnt_base + NUM_W'(1));
    end else begin
      r_pulse_cnt <= w_cnt_base;
    end
  end

  // Output flops decoded from the next state so INJ_OUT/BUSY/DONE are clean registers.
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_inj  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_inj  <= (w_state_next == ST_HIGH);
      r_busy <= (w_state_next != ST_IDLE);
      r_done <= w_done_next;
    end
  end

  assign INJ_OUT   = r_inj;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PULSE_CNT = r_pulse_cnt;

endmodule

// File: tb/tb_afe_inj_pulser.sv
// Scoreboard bench: stimulus queues expected output transitions, a monitor pops and compares them.
module tb_afe_inj_pulser;

  logic        clk = 1'b0;
  logic        rst_b, start, abort, start4, abort4;
  logic [15:0] delay, width, period;
  logic [7:0]  num;
  logic [3:0]  num4;
  logic        inj, busy, done;
  logic [7:0]  pcnt;
  logic        inj4, busy4, done4;
  logic [3:0]  pcnt4;

  always #5 clk = ~clk;

  afe_inj_pulser #(.CNT_W(16), .NUM_W(8)) u_dut (
    .CLK(clk), .RST_B(rst_b), .START(start), .ABORT(abort),
    .DELAY(delay), .WIDTH(width), .PERIOD(period), .NUM_PULSES(num),
    .INJ_OUT(inj), .BUSY(busy), .DONE(done), .PULSE_CNT(pcnt)
  );

  afe_inj_pulser #(.CNT_W(16), .NUM_W(4)) u_dut4 (
    .CLK(clk), .RST_B(rst_b), .START(start4), .ABORT(abort4),
    .DELAY(delay), .WIDTH(width), .PERIOD(period), .NUM_PULSES(num4),
    .INJ_OUT(inj4), .BUSY(busy4), .DONE(done4), .PULSE_CNT(pcnt4)
  );

  typedef struct {
    int         cyc;
    logic       inj;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  t0 = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected output transition at cycle t0+rel (t0 = cycle in which START is driven).
  task automatic ex(input int rel, input logic i, input logic b, input logic d, input int c);
    ev_t e;
    e.cyc = t0 + rel; e.inj = i; e.busy = b; e.done = d; e.cnt = 8'(c);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d (cyc %0d)", name, got, req, cyc);
    end else begin
      $display("check %s = %0d ok (cyc %0d)", name, got, cyc);
    end
  endtask

  task automatic arm();
    @(negedge clk);
    t0 = cyc;
  endtask

  task automatic fire(input int d, input int w, input int p, input int n);
    delay = 16'(d); width = 16'(w); period = 16'(p); num = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("start burst d=%0d w=%0d p=%0d n=%0d at cyc %0d", d, w, p, n, t0);
  endtask

  task automatic goto(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  // Monitor: any change of INJ_OUT/BUSY/DONE is an output event compared against the queue.
  initial begin
    logic p_inj, p_busy, p_done;
    ev_t  e;
    p_inj = 1'b0; p_busy = 1'b0; p_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (inj !== p_inj || busy !== p_busy || done !== p_done)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got inj=%b busy=%b done=%b cnt=%0d, required none",
                   cyc, inj, busy, done, pcnt);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.inj !== inj || e.busy !== busy || e.done !== done || e.cnt !== pcnt) begin
            errors++;
            $display("FAIL event got cyc=%0d inj=%b busy=%b done=%b cnt=%0d required cyc=%0d inj=%b busy=%b done=%b cnt=%0d",
                     cyc, inj, busy, done, pcnt, e.cyc, e.inj, e.busy, e.done, e.cnt);
          end else begin
            $display("event ok cyc=%0d inj=%b busy=%b done=%b cnt=%0d", cyc, inj, busy, done, pcnt);
          end
        end
      end
      p_inj = inj; p_busy = busy; p_done = done;
    end
  end

  initial begin
    int   rises;
    logic prev;
    rst_b = 1'b0; start = 1'b0; abort = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    delay = '0; width = '0; period = '0; num = '0; num4 = '0;
    repeat (3) @(negedge clk);
    chk("reset_inj", int'(inj), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_cnt", int'(pcnt), 0);
    chk("reset_cnt4", int'(pcnt4), 0);
    rst_b = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Test 1: D=0 W=3 P=10 N=4: high 1-3,11-13,21-23,31-33; DONE at 41.
    arm();
    for (int k = 0; k < 4; k++) begin
      ex(1 + 10 * k, 1, 1, 0, k + 1);
      ex(4 + 10 * k, 0, 1, 0, k + 1);
    end
    ex(41, 0, 0, 1, 4);
    ex(42, 0, 0, 0, 4);
    fire(0, 3, 10, 4);
    goto(45);

    // Test 2: D=5 W=0 P=0 N=2: busy at 1, rises 6 and 8, DONE at 10.
    arm();
    ex(1, 0, 1, 0, 0);
    ex(6, 1, 1, 0, 1);
    ex(7, 0, 1, 0, 1);
    ex(8, 1, 1, 0, 2);
    ex(9, 0, 1, 0, 2);
    ex(10, 0, 0, 1, 2);
    ex(11, 0, 0, 0, 2);
    fire(5, 0, 0, 2);
    goto(14);

    // Test 3: continuous W=2 P=4, ABORT in cycle 9: idle at 10, count 3, no DONE.
    arm();
    ex(1, 1, 1, 0, 1);
    ex(3, 0, 1, 0, 1);
    ex(5, 1, 1, 0, 2);
    ex(7, 0, 1, 0, 2);
    ex(9, 1, 1, 0, 3);
    ex(10, 0, 0, 0, 3);
    fire(0, 2, 4, 0);
    goto(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    goto(14);
    chk("abort_cnt_hold", int'(pcnt), 3);

    // Test 4a: START with ABORT while idle is ignored.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; delay = 16'd0; width = 16'd2; period = 16'd4; num = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    chk("start_abort_inj", int'(inj), 0);
    chk("start_abort_cnt", int'(pcnt), 3);

    // Test 4b: D=0 W=2 P=5 N=3, re-START and setting changes mid-burst have no effect.
    arm();
    for (int k = 0; k < 3; k++) begin
      ex(1 + 5 * k, 1, 1, 0, k + 1);
      ex(3 + 5 * k, 0, 1, 0, k + 1);
    end
    ex(16, 0, 0, 1, 3);
    ex(17, 0, 0, 0, 3);
    fire(0, 2, 5, 3);
    goto(4);
    start = 1'b1; width = 16'd7; delay = 16'd9; period = 16'd20; num = 8'd1;
    @(negedge clk);
    start = 1'b0;
    goto(20);

    // Test 5: reset while HIGH clears everything; a new burst then runs normally.
    arm();
    ex(1, 1, 1, 0, 1);
    ex(3, 0, 0, 0, 0);
    fire(0, 4, 8, 2);
    goto(2);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    chk("reset_mid_cnt", int'(pcnt), 0);
    chk("reset_mid_done", int'(done), 0);
    arm();
    ex(1, 0, 1, 0, 0);
    ex(2, 1, 1, 0, 1);
    ex(3, 0, 1, 0, 1);
    ex(5, 1, 1, 0, 2);
    ex(6, 0, 1, 0, 2);
    ex(8, 0, 0, 1, 2);
    ex(9, 0, 0, 0, 2);
    fire(1, 1, 3, 2);
    goto(12);

    // Test 6: NUM_W=4 instance, continuous W=1 P=2: 20 pulses, count saturates at 15.
    @(negedge clk);
    t0 = cyc;
    delay = 16'd0; width = 16'd1; period = 16'd2; num4 = 4'd0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    rises = 0;
    prev = 1'b0;
    for (int r = 1; r <= 40; r++) begin
      goto(r);
      if (inj4 && !prev) rises++;
      prev = inj4;
    end
    chk("sat_rises", rises, 20);
    chk("sat_cnt", int'(pcnt4), 15);
    goto(41);
    chk("sat_still_pulsing", int'(inj4), 1);
    chk("sat_busy", int'(busy4), 1);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    chk("sat_abort_busy", int'(busy4), 0);
    chk("sat_abort_cnt", int'(pcnt4), 15);
    chk("sat_abort_done", int'(done4), 0);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
